delay_line: RTL and testbench
=============================

Name: delay_line

Overview:
- Parameterised fixed-latency register pipeline.
- Presents input vector D on output Q exactly DEPTH clock cycles later.
- Used to re-align side-band data with the output of clocked lookups. Example: the video terminal delays pixel coordinates {X,Y} by one cycle to match its grid-RAM read latency.
- Pure datapath: no handshake, no flow control.

Parameters:
- W, 1, data width in bits; must be ≥ 1.
- DEPTH, 1, number of register stages (latency in cycles); must be ≥ 0. 0 = combinational pass-through.
- RESET_VAL, 0 (W bits), value loaded into every stage on reset.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- D    input  W  data in.
- Q    output W  data out, i.e. D delayed by DEPTH cycles.

Behaviour:
- Stage chain s[0..DEPTH-1].
  - On each rising CLK edge with RST=0: s[0] <= D; s[i] <= s[i-1] for i ≥ 1.
  - Q = s[DEPTH-1].
- Latency: a value on D sampled at edge k appears on Q right after edge k+DEPTH-1. Q(t) = D(t-DEPTH) in cycle units.
- DEPTH=0: Q = D combinationally. No registers; CLK and RST unused.
- Reset:
  - At an edge with RST=1, all stages load RESET_VAL, so Q = RESET_VAL after that edge.
  - Reset has priority over data shift.
  - Reset takes effect only at a clock edge; asserting RST between edges does not change Q.
- Power-up before the first reset: stage contents undefined (X in simulation). No initial values are required.
- After RST falls: Q remains RESET_VAL for DEPTH-1 further cycles, then shows the first post-reset D.
- Reset mid-stream: all in-flight data is discarded, with no partial flush.
- Full throughput: a new value is accepted every cycle. No bubbles, no back-pressure.
- Width: bitwise transport, no arithmetic, no sign handling. Every bit of D propagates unchanged.

Optional Feature:
- Macro: DELAY_LINE_CE_EN.
- Defined:
  - Adds port CE (input, 1 bit, placed after RST).
  - With CE=0 and RST=0, every stage holds its value and Q is frozen.
  - With CE=1, behaviour is as above.
  - RST overrides CE: reset applies even when CE=0.
  - With DEPTH=0, CE has no effect.
- Not defined: no CE port; stages shift every cycle.

Decomposition:
- Shared package delay_line_pkg:
  - Default-width constant DELAY_LINE_DEFAULT_W = 1.
  - Default-depth constant DELAY_LINE_DEFAULT_DEPTH = 1.
  - No typedefs needed; data is an untyped W-bit vector.
- Sub-module delay_stage:
  - One W-bit register with synchronous RST to RESET_VAL and optional CE.
  - delay_line instantiates DEPTH of these in a generate loop.
  - The DEPTH=0 branch is a direct assign.

Test Plan:
- DEPTH=1, W=8: reset, then drive D=0x11,0x22,0x33 on consecutive edges -> Q=0x00 on the first post-reset cycle, then 0x11, 0x22, 0x33, each exactly 1 cycle after its D.
- DEPTH=4, W=16, RESET_VAL=0xBEEF: reset, then stream an incrementing counter starting at 0 -> Q=0xBEEF for 4 cycles after reset release, then 0,1,2,… with no gaps.
- DEPTH=3: stream 0xA,0xB,0xC,0xD, assert RST for one edge after 0xB enters -> Q=RESET_VAL on the next cycle and for 2 more cycles; 0xA/0xB never appear after the reset edge.
- DEPTH=0, W=4: toggle D 0x5->0xA mid-cycle -> Q follows immediately; RST has no effect.
- DELAY_LINE_CE_EN, DEPTH=2:
  - Drive 1,2,3 with CE=1, then CE=0 for 3 cycles while D=9 -> Q holds its last value, and 9 never enters the chain.
  - RST=1 with CE=0 -> Q=RESET_VAL.
- W=21 (e.g. a 10-bit X plus an 11-bit Y concatenation), DEPTH=1, random D for 1000 cycles -> Q equals D from the previous cycle on every cycle.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared constants for the delay_line block: default width and depth.
// Data is an untyped W-bit vector, so no typedefs are needed here.
package delay_line_pkg;

  localparam int DELAY_LINE_DEFAULT_W     = 1;
  localparam int DELAY_LINE_DEFAULT_DEPTH = 1;

endpackage : delay_line_pkg

// File: rtl/delay_stage.sv
// One register stage of delay_line: W-bit flop with synchronous active-high
// reset to RESET_VAL. When DELAY_LINE_CE_EN is defined the stage also has a
// clock enable CE; reset still wins when CE is low.
module delay_stage
  import delay_line_pkg::*;
#(
  parameter int             W         = DELAY_LINE_DEFAULT_W,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
`ifdef DELAY_LINE_CE_EN
  input  logic         CE,
`endif
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

`ifdef DELAY_LINE_CE_EN
  // Reset has priority; otherwise load D only when enabled, else hold.
  always_ff @(posedge CLK) begin
    if (RST)     Q <= RESET_VAL;
    else if (CE) Q <= D;
  end
`else
  // Reset has priority; otherwise load D every cycle.
  always_ff @(posedge CLK) begin
    if (RST) Q <= RESET_VAL;
    else     Q <= D;
  end
`endif

endmodule : delay_stage

// File: rtl/delay_line.sv
// Fixed-latency register pipeline: Q is D delayed by DEPTH clock cycles.
// DEPTH=0 degenerates to a combinational wire (CLK/RST unused).
// Optional clock enable CE is compiled in with `define DELAY_LINE_CE_EN.
// Pure datapath: no handshake, a new value is accepted every cycle.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int           W         = DELAY_LINE_DEFAULT_W,
  parameter int           DEPTH     = DELAY_LINE_DEFAULT_DEPTH,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
`ifdef DELAY_LINE_CE_EN
  input  logic         CE,
`endif
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No storage: clock, reset and enable are intentionally ignored.
`ifdef DELAY_LINE_CE_EN
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, RST, CE};
`else
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, RST};
`endif
      assign Q = D;
    end else begin : g_chain
      // s[i] is the output of stage i; stage 0 samples D directly.
      logic [W-1:0] s [DEPTH];

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [W-1:0] stage_in;
        if (i == 0) begin : g_first
          assign stage_in = D;
        end else begin : g_rest
          assign stage_in = s[i-1];
        end

        delay_stage #(
          .W         (W),
          .RESET_VAL (RESET_VAL)
        ) u_stage (
          .CLK (CLK),
          .RST (RST),
`ifdef DELAY_LINE_CE_EN
          .CE  (CE),
`endif
          .D   (stage_in),
          .Q   (s[i])
        );
      end

      assign Q = s[DEPTH-1];
    end
  endgenerate

endmodule : delay_line

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line. Several instances with different
// W/DEPTH/RESET_VAL share one stimulus bus; a phase selector picks which
// instance the scoreboard currently watches. The driver pushes the expected
// output sequence into exp_q (reset loads DEPTH copies of RESET_VAL, each
// enabled edge appends D); the monitor pops one entry on every falling edge.
module tb_delay_line;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b1;
  logic [31:0] d   = '0;

  logic [7:0]  q_d1;
  logic [15:0] q_d4;
  logic [7:0]  q_d3;
  logic [3:0]  q_d0;
  logic [20:0] q_w21;
  logic [7:0]  q_ce;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] last_q    = '0;
  logic        check_en  = 1'b0;
  int          phase     = 0;
  int          cur_depth = 1;
  logic [31:0] cur_rv    = '0;
  logic [31:0] cur_mask  = '0;
  logic [31:0] q_sel;

  // clock / reset block
  always #5 clk = ~clk;

  delay_line #(.W(8), .DEPTH(1), .RESET_VAL(8'h00)) u_d1 (
    .CLK(clk), .RST(rst),
`ifdef DELAY_LINE_CE_EN
    .CE(ce),
`endif
    .D(d[7:0]), .Q(q_d1));

  delay_line #(.W(16), .DEPTH(4), .RESET_VAL(16'hBEEF)) u_d4 (
    .CLK(clk), .RST(rst),
`ifdef DELAY_LINE_CE_EN
    .CE(ce),
`endif
    .D(d[15:0]), .Q(q_d4));

  delay_line #(.W(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_d3 (
    .CLK(clk), .RST(rst),
`ifdef DELAY_LINE_CE_EN
    .CE(ce),
`endif
    .D(d[7:0]), .Q(q_d3));

  delay_line #(.W(4), .DEPTH(0), .RESET_VAL(4'h0)) u_d0 (
    .CLK(clk), .RST(rst),
`ifdef DELAY_LINE_CE_EN
    .CE(ce),
`endif
    .D(d[3:0]), .Q(q_d0));

  delay_line #(.W(21), .DEPTH(1), .RESET_VAL(21'h0)) u_w21 (
    .CLK(clk), .RST(rst),
`ifdef DELAY_LINE_CE_EN
    .CE(ce),
`endif
    .D(d[20:0]), .Q(q_w21));

  delay_line #(.W(8), .DEPTH(2), .RESET_VAL(8'h3C)) u_ce (
    .CLK(clk), .RST(rst),
`ifdef DELAY_LINE_CE_EN
    .CE(ce),
`endif
    .D(d[7:0]), .Q(q_ce));

  // Route the output of the instance under test to the monitor.
  always_comb begin
    q_sel = '0;
    case (phase)
      1: q_sel = {24'h0, q_d1};
      2: q_sel = {16'h0, q_d4};
      3: q_sel = {24'h0, q_d3};
      5: q_sel = {11'h0, q_w21};
      6: q_sel = {24'h0, q_ce};
      default: q_sel = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_dut(input int ph, input int depth, input logic [31:0] rv,
                         input logic [31:0] mask);
    check_en  = 1'b0;
    exp_q.delete();
    phase     = ph;
    cur_depth = depth;
    cur_rv    = rv;
    cur_mask  = mask;
  endtask

  // Driver: apply one cycle of inputs, then record what the chain must show.
  task automatic step(input logic [31:0] dv, input logic r, input logic c);
    d   = dv;
    rst = r;
    ce  = c;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      repeat (cur_depth) exp_q.push_back(cur_rv);
    end else if (c) begin
      exp_q.push_back(dv & cur_mask);
    end else begin
      exp_q.push_front(last_q);
    end
    check_en = 1'b1;
  endtask

  // Monitor / scoreboard: one expected output per cycle while checking.
  always @(negedge clk) begin
    if (check_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: phase=%0d got=%h expected=none", phase, q_sel);
      end else begin
        last_q = exp_q.pop_front();
        chk($sformatf("q_phase%0d", phase), q_sel, last_q);
      end
    end
  end

  // Watchdog: every wait is clock-bound, this only guards a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // DEPTH=1, W=8: reset then 0x11,0x22,0x33.
    set_dut(1, 1, 32'h00, 32'hFF);
    step(32'h00, 1'b1, 1'b1);
    step(32'h11, 1'b0, 1'b1);
    // RST raised between edges must not disturb Q.
    rst = 1'b1;
    #2;
    chk("mid_cycle_rst_hold", {24'h0, q_d1}, exp_q[0]);
    rst = 1'b0;
    step(32'h22, 1'b0, 1'b1);
    step(32'h33, 1'b0, 1'b1);
    step(32'h00, 1'b0, 1'b1);
    @(negedge clk); #1;

    // DEPTH=4, W=16, RESET_VAL=BEEF: counter stream with no gaps.
    set_dut(2, 4, 32'hBEEF, 32'hFFFF);
    step(32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(32'(i), 1'b0, 1'b1);
    @(negedge clk); #1;

    // DEPTH=3: reset mid-stream discards 0xA/0xB.
    set_dut(3, 3, 32'h5A, 32'hFF);
    step(32'h0, 1'b1, 1'b1);
    step(32'hA, 1'b0, 1'b1);
    step(32'hB, 1'b0, 1'b1);
    step(32'hC, 1'b1, 1'b1);
    step(32'hD, 1'b0, 1'b1);
    step(32'hE, 1'b0, 1'b1);
    step(32'hF, 1'b0, 1'b1);
    step(32'h10, 1'b0, 1'b1);
    step(32'h11, 1'b0, 1'b1);
    @(negedge clk); #1;

    // DEPTH=0, W=4: combinational, reset ignored.
    set_dut(4, 0, 32'h0, 32'hF);
    d = 32'h5;
    #1;
    chk("pass_5", {28'h0, q_d0}, 32'h5);
    rst = 1'b1;
    d   = 32'hA;
    #1;
    chk("pass_A_rst", {28'h0, q_d0}, 32'hA);
    @(posedge clk); #1;
    chk("pass_A_after_edge", {28'h0, q_d0}, 32'hA);
    rst = 1'b0;
    d   = 32'h3;
    #1;
    chk("pass_3", {28'h0, q_d0}, 32'h3);

    // W=21, DEPTH=1: random data, every bit must travel unchanged.
    set_dut(5, 1, 32'h0, 32'h1F_FFFF);
    step(32'h0, 1'b1, 1'b1);
    step(32'h1F_FFFF, 1'b0, 1'b1);
    step(32'h15_5555, 1'b0, 1'b1);
    step(32'h0A_AAAA, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) step($urandom_range(32'h1F_FFFF, 0), 1'b0, 1'b1);
    @(negedge clk); #1;

`ifdef DELAY_LINE_CE_EN
    // DEPTH=2 with clock enable: hold, then reset overriding CE=0.
    set_dut(6, 2, 32'h3C, 32'hFF);
    step(32'h0, 1'b1, 1'b1);
    step(32'h1, 1'b0, 1'b1);
    step(32'h2, 1'b0, 1'b1);
    step(32'h3, 1'b0, 1'b1);
    step(32'h9, 1'b0, 1'b0);
    step(32'h9, 1'b0, 1'b0);
    step(32'h9, 1'b0, 1'b0);
    step(32'h4, 1'b0, 1'b1);
    step(32'h5, 1'b0, 1'b1);
    step(32'h6, 1'b1, 1'b0);
    step(32'h7, 1'b0, 1'b0);
    @(negedge clk); #1;
`endif

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_delay_line
